// File: rtl/controle_saida.sv
// controle_saida -- output-side result presenter.
//
// Captures a computed result when valid_i is high and shows it on out_o one
// nibble at a time, most significant nibble first. Each press of the
// active-low step button next_i advances one nibble. done_o rises once every
// nibble has been stepped through. After done, a new result is accepted only
// once valid_i has dropped low and then risen again.
//
// Optional build macro: CONTROLE_SAIDA_DEBOUNCE_EN
//   Defined   : a press needs DEBOUNCE_CYCLES consecutive low samples.
//   Undefined : a press is a plain falling-edge detect.
//
// Parameters:
//   RESULT_W        result width in bits (multiple of 4, >= 4)
//   DEBOUNCE_CYCLES stable low samples per press (debounce build only)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   valid_i      result available (level)
//   result_i     result to display
//   next_i       step button, active low, asynchronous to clk_i
//   out_o        current nibble
//   out_valid_o  out_o holds a result nibble
//   nibble_idx_o index of the shown nibble, 0 = MSN
//   busy_o       result captured, presentation in progress
//   done_o       all nibbles stepped through
module controle_saida #(
  parameter int RESULT_W        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int N_NIB = RESULT_W / 4,
  localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [RESULT_W-1:0] result_i,
  input  logic                next_i,
  output logic [3:0]          out_o,
  output logic                out_valid_o,
  output logic [IDX_W-1:0]    nibble_idx_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_SHOW = 2'd1,
    OUT_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);

  state_t              state_q, state_d;
  logic [RESULT_W-1:0] capture_q, capture_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [3:0]          out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Button synchronizer; flops idle high so reset never looks like a press.
  logic sync1_q, sync2_q;
  logic press;

`ifdef CONTROLE_SAIDA_DEBOUNCE_EN
  // Counter saturates one above the hit value, so a held button matches
  // the hit value for exactly one cycle.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign press = ~sync2_q && (cnt_q == CNT_HIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic prev_q;

  assign press = prev_q & ~sync2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sync2_q;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= next_i;
      sync2_q <= sync1_q;
    end
  end

  // Shifting the selected nibble to the top avoids a variable part-select.
  logic [RESULT_W-1:0] shifted;

  always_comb begin
    state_d   = state_q;
    capture_d = capture_q;
    idx_d     = idx_q;

    case (state_q)
      OUT_IDLE: begin
        if (valid_i) begin
          capture_d = result_i;
          idx_d     = '0;
          state_d   = OUT_SHOW;
        end
      end
      OUT_SHOW: begin
        if (press) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = OUT_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      OUT_DONE: begin
        idx_d = '0;
        // Waiting for valid_i low keeps a held compute flag from re-triggering.
        if (!valid_i) begin
          state_d = OUT_IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = OUT_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they register together.
    shifted     = capture_d << (4 * idx_d);
    out_d       = 4'h0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      OUT_SHOW: begin
        out_d       = shifted[RESULT_W-1 -: 4];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      OUT_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= OUT_IDLE;
      capture_q   <= '0;
      idx_q       <= '0;
      out_q       <= 4'h0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_o        = out_q;
  assign out_valid_o  = out_valid_q;
  assign nibble_idx_o = idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_controle_saida.sv
// Testbench for controle_saida: two instances (RESULT_W = 8 and 12) share
// clock, reset, valid and button; each is compared every cycle against a
// behavioural model of the presentation sequence.
module tb_controle_saida;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        next_i;
  logic [7:0]  res8;
  logic [11:0] res12;

  logic [3:0] out8, out12;
  logic       ov8, ov12, busy8, busy12, done8, done12;
  logic [0:0] idx8;
  logic [1:0] idx12;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  controle_saida #(.RESULT_W(8)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .result_i(res8),
    .next_i(next_i), .out_o(out8), .out_valid_o(ov8),
    .nibble_idx_o(idx8), .busy_o(busy8), .done_o(done8)
  );

  controle_saida #(.RESULT_W(12)) dut12 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .result_i(res12),
    .next_i(next_i), .out_o(out12), .out_valid_o(ov12),
    .nibble_idx_o(idx12), .busy_o(busy12), .done_o(done12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 showing, 2 done. Button history holds
  // next_i as seen at the last three edges; a press acts at an edge when the
  // value two edges back is low and the one three edges back is high.
  int          ph  [2];
  int          idx [2];
  int          cap [2];
  int          nnib[2] = '{2, 3};
  logic        h1, h2, h3;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; idx[i] = 0; cap[i] = 0;
    end
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
  endtask

  task automatic model_step();
    logic press;
    int   r;
    press = h3 && !h2;
    for (int i = 0; i < 2; i++) begin
      r = (i == 0) ? int'(res8) : int'(res12);
      case (ph[i])
        0: if (valid_i) begin cap[i] = r; idx[i] = 0; ph[i] = 1; end
        1: if (press) begin
             if (idx[i] < nnib[i] - 1) idx[i]++;
             else begin ph[i] = 2; idx[i] = 0; end
           end
        default: if (!valid_i) ph[i] = 0;
      endcase
    end
    h3 = h2; h2 = h1; h1 = next_i;
  endtask

  function automatic logic [31:0] expected(input int i);
    int nib;
    nib = (cap[i] >> (4 * (nnib[i] - 1 - idx[i]))) & 15;
    // packed as {out, out_valid, busy, done, idx[1:0]}
    case (ph[i])
      1:       return {23'd0, nib[3:0], 3'b110, idx[i][1:0]};
      2:       return {23'd0, 4'h0, 3'b001, 2'd0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic compare(input string where);
    chk({where, "/w8"},  {23'd0, out8, ov8, busy8, done8, 1'b0, idx8}, expected(0));
    chk({where, "/w12"}, {23'd0, out12, ov12, busy12, done12, idx12}, expected(1));
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare("cyc");
  endtask

  task automatic hold_low(input int n);
    next_i = 1'b0;
    repeat (n) cycle();
    next_i = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic mid_reset();
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    compare("rst");
    #1 rst_i = 1'b1;
  endtask

  initial begin
    int vrun, nrun;
    rst_i = 1'b0; valid_i = 1'b0; next_i = 1'b1; res8 = '0; res12 = '0;
    model_reset();
    @(negedge clk);
    compare("por");
    rst_i = 1'b1;
    repeat (10) cycle();

    // press while idle does nothing
    hold_low(2);

    // capture and ignore later result changes
    res8 = 8'hA5; res12 = 12'h9E1; valid_i = 1'b1;
    cycle();
    chk("msn8", {28'd0, out8}, 32'hA);
    chk("msn12", {28'd0, out12}, 32'h9);
    res8 = 8'hFF; res12 = 12'hFFF;
    repeat (3) cycle();
    chk("stable8", {28'd0, out8}, 32'hA);

    // two edges after the sampled low nothing yet, third edge advances
    next_i = 1'b0;
    cycle(); cycle();
    chk("pre_adv8", {28'd0, out8}, 32'hA);
    cycle();
    chk("adv8", {28'd0, out8}, 32'h5);
    chk("adv12", {28'd0, out12}, 32'hE);
    // held low for 20 cycles total: still one advance only
    repeat (17) cycle();
    next_i = 1'b1;
    repeat (4) cycle();
    chk("hold_idx8", {31'd0, idx8}, 32'd1);
    chk("hold_idx12", {30'd0, idx12}, 32'd1);

    hold_low(1);
    chk("done8", {31'd0, done8}, 32'd1);
    chk("lsn12", {28'd0, out12}, 32'h1);
    repeat (10) cycle();
    chk("no_rearm8", {31'd0, done8}, 32'd1);
    hold_low(1);
    chk("done12", {31'd0, done12}, 32'd1);

    valid_i = 1'b0;
    cycle();
    res8 = 8'h3C; res12 = 12'h3C0; valid_i = 1'b1;
    cycle();
    chk("rearm8", {28'd0, out8}, 32'h3);
    valid_i = 1'b0;
    cycle();

    mid_reset();
    repeat (3) cycle();

    // randomized phase
    vrun = 1; nrun = 1;
    for (int c = 0; c < 4000; c++) begin
      if (--vrun == 0) begin
        valid_i = ~valid_i;
        vrun = $urandom_range(1, 40);
      end
      if (--nrun == 0) begin
        next_i = ~next_i;
        nrun = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 7) == 0) begin
        res8 = 8'($urandom);
        res12 = 12'($urandom);
      end
      cycle();
      if ($urandom_range(0, 699) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
